// File: rtl/rr_arbiter_param_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_param_pkg
// Shared definitions for the round-robin arbiter family.
//   clog2()   : ceiling log2 of a positive integer
//   idw_for() : width of an encoded channel index for n channels (at least 1)
//   arb_state_t : arbiter state, idle or granting
// ----------------------------------------------------------------------------
package rr_arbiter_param_pkg;

    // Ceiling log2, evaluated at elaboration time when used for widths.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Encoded-index width. Kept at least 1 bit so ports never collapse to zero width.
    function automatic int idw_for(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Arbiter state. The owning channel lives in the pointer register, not here.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_param_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating priority encoder. Searches req starting at
// pointer+1, wrapping modulo N, with the pointer channel itself checked last.
//   req     [N]   : request vector
//   pointer [IDW] : channel most recently served
//   found   [1]   : any request bit set
//   winner  [IDW] : first requesting channel in rotation order (0 if none)
// ----------------------------------------------------------------------------
module rr_priority_pick
    import rr_arbiter_param_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw_for(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] pointer,
    output logic           found,
    output logic [IDW-1:0] winner
);

    // Walk the N candidates in rotation order and keep the first one that is
    // requesting. Using modulo N keeps the wrap correct when N is not a power
    // of two.
    always_comb begin
        logic [IDW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDW'((int'(pointer) + i) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_param.sv
// ----------------------------------------------------------------------------
// rr_arbiter_param
// N-way round-robin arbiter with a per-burst hold quota, lock override and
// early release. Grants are registered (one cycle after req is sampled).
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   req   [N]   : level-sensitive requests
//   quota [HOLD_W] : burst length minus one, latched at each burst start
//   lock        : owner keeps the grant past its quota while its req stays high
//   grant [N]   : one-hot grant, zero when idle
//   grant_id [IDW] : encoded grant, zero when idle
//   grant_valid : a grant is active
//   grant_new   : pulses on the first cycle of every burst
// ----------------------------------------------------------------------------
module rr_arbiter_param
    import rr_arbiter_param_pkg::*;
#(
    parameter int N = 4,
    parameter int HOLD_W = 2,
    localparam int IDW = idw_for(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [HOLD_W-1:0] quota,
    input  logic              lock,
    output logic [N-1:0]      grant,
    output logic [IDW-1:0]    grant_id,
    output logic              grant_valid,
    output logic              grant_new
);

    arb_state_t        state, state_nxt;
    logic [IDW-1:0]    ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [HOLD_W-1:0] quota_q, quota_nxt;
    logic [N-1:0]      grant_nxt;
    logic [IDW-1:0]    id_nxt;
    logic              new_nxt;
    logic              keep_owner;
    logic              pick_found;
    logic [IDW-1:0]    pick_winner;

    // The search always starts just after the last owner, so the pointer
    // doubles as the owner while granting and as the fairness point when idle.
    rr_priority_pick #(
        .N(N)
    ) u_pick (
        .req     (req),
        .pointer (ptr),
        .found   (pick_found),
        .winner  (pick_winner)
    );

    // The owner stays while it still requests and either has quota left or is
    // locked. Anything else (expiry, early release, idle) falls through to a
    // fresh rotating search, so a sole requester whose quota runs out is simply
    // re-selected as a new burst.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        hold_nxt   = hold_cnt;
        quota_nxt  = quota_q;
        grant_nxt  = '0;
        id_nxt     = '0;
        new_nxt    = 1'b0;
        keep_owner = (state == ST_GRANT) && req[ptr] && ((hold_cnt < quota_q) || lock);

        if (keep_owner) begin
            hold_nxt  = (hold_cnt < quota_q) ? hold_cnt + 1'b1 : hold_cnt;
            grant_nxt = grant;
            id_nxt    = grant_id;
        end else if (pick_found) begin
            state_nxt = ST_GRANT;
            ptr_nxt   = pick_winner;
            hold_nxt  = '0;
            quota_nxt = quota;
            grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick_winner;
            id_nxt    = pick_winner;
            new_nxt   = 1'b1;
        end else begin
            state_nxt = ST_IDLE;
        end
    end

    // State and output registers. The pointer resets to the last channel so
    // the first search after reset begins at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= IDW'(N - 1);
            hold_cnt  <= '0;
            quota_q   <= '0;
            grant     <= '0;
            grant_id  <= '0;
            grant_new <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            quota_q   <= quota_nxt;
            grant     <= grant_nxt;
            grant_id  <= id_nxt;
            grant_new <= new_nxt;
        end
    end

    assign grant_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter_param.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_param
// Self-checking bench for rr_arbiter_param (N=4, HOLD_W=2): a table of
// directed vectors, hand-written reset sequences, then random traffic
// compared against a burst-level reference model.
// ----------------------------------------------------------------------------
module tb_rr_arbiter_param;

    localparam int N = 4;
    localparam int HOLD_W = 2;
    localparam int IDW = 2;

    typedef struct {
        logic [N-1:0]      req;
        logic [HOLD_W-1:0] quota;
        logic              lock;
        logic [N-1:0]      grant;
        logic [IDW-1:0]    id;
        logic              gnew;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [HOLD_W-1:0] quota;
    logic              lock;
    logic [N-1:0]      grant;
    logic [IDW-1:0]    grant_id;
    logic              grant_valid;
    logic              grant_new;

    int checks;
    int failures;
    vec_t vecs[$];

    int m_owner;
    bit m_active;
    int m_used;
    int m_len;

    rr_arbiter_param #(
        .N(N),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .quota       (quota),
        .lock        (lock),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .grant_new   (grant_new)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one directed vector: inputs for an edge and the outputs expected after it.
    task automatic addVec(input logic [N-1:0] r, input logic [HOLD_W-1:0] q, input logic l,
                          input logic [N-1:0] g, input logic [IDW-1:0] id, input logic gn);
        vec_t v;
        v.req = r; v.quota = q; v.lock = l; v.grant = g; v.id = id; v.gnew = gn;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1 unit later.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [HOLD_W-1:0] q, input logic l);
        @(negedge clk);
        req = r;
        quota = q;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values.
    task automatic checkOutput(input string name, input logic [N-1:0] eg, input logic [IDW-1:0] eid,
                               input logic ev, input logic en);
        checks++;
        if (grant !== eg) begin
            failures++;
            $display("[TB] FAIL %s grant: got %b want %b", name, grant, eg);
        end
        checks++;
        if (grant_id !== eid) begin
            failures++;
            $display("[TB] FAIL %s grant_id: got %0d want %0d", name, grant_id, eid);
        end
        checks++;
        if (grant_valid !== ev) begin
            failures++;
            $display("[TB] FAIL %s grant_valid: got %b want %b", name, grant_valid, ev);
        end
        checks++;
        if (grant_new !== en) begin
            failures++;
            $display("[TB] FAIL %s grant_new: got %b want %b", name, grant_new, en);
        end
    endtask

    // Reference model reset: nobody owns, rotation begins at channel 0.
    task automatic modelReset();
        m_owner = N - 1;
        m_active = 0;
        m_used = 0;
        m_len = 1;
    endtask

    // Reference model, one clock edge. A burst is "m_len cycles of ownership";
    // the owner continues while requesting and either inside its burst or locked.
    // Otherwise the requesters are ranked by distance after the previous owner.
    task automatic modelStep(input logic [N-1:0] r, input logic [HOLD_W-1:0] q, input logic l,
                             output logic [N-1:0] eg, output logic [IDW-1:0] eid,
                             output logic ev, output logic en);
        int pick;
        pick = -1;
        en = 1'b0;
        if (m_active && r[m_owner] && (m_used < m_len || l)) begin
            m_used++;
        end else begin
            for (int d = 1; d <= N; d++) begin
                if (pick < 0 && r[(m_owner + d) % N]) pick = (m_owner + d) % N;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_active = 1;
                m_used = 1;
                m_len = int'(q) + 1;
                en = 1'b1;
            end else begin
                m_active = 0;
            end
        end
        eg = m_active ? (N'(1) << m_owner) : '0;
        eid = m_active ? IDW'(m_owner) : '0;
        ev = m_active;
    endtask

    initial begin
        logic [N-1:0] eg;
        logic [IDW-1:0] eid;
        logic ev;
        logic en;
        logic [N-1:0] rr;
        logic [HOLD_W-1:0] rq;
        logic rl;

        checks = 0;
        failures = 0;

        // Directed vectors: full rotation at quota 3, idle, alternation at quota 0,
        // sole requester re-selection, pointer retention, early release, lock.
        for (int i = 0; i < 4; i++) addVec(4'b1111, 2'd3, 1'b0, 4'b0001, 2'd0, i == 0);
        for (int i = 0; i < 4; i++) addVec(4'b1111, 2'd3, 1'b0, 4'b0010, 2'd1, i == 0);
        for (int i = 0; i < 4; i++) addVec(4'b1111, 2'd3, 1'b0, 4'b0100, 2'd2, i == 0);
        for (int i = 0; i < 4; i++) addVec(4'b1111, 2'd3, 1'b0, 4'b1000, 2'd3, i == 0);
        addVec(4'b1111, 2'd3, 1'b0, 4'b0001, 2'd0, 1'b1);
        addVec(4'b0000, 2'd3, 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            addVec(4'b0101, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b1);
            addVec(4'b0101, 2'd0, 1'b0, 4'b0001, 2'd0, 1'b1);
        end
        for (int i = 0; i < 9; i++) addVec(4'b0010, 2'd3, 1'b0, 4'b0010, 2'd1, (i % 4) == 0);
        addVec(4'b0000, 2'd3, 1'b0, 4'b0000, 2'd0, 1'b0);
        addVec(4'b1111, 2'd3, 1'b0, 4'b0100, 2'd2, 1'b1);
        addVec(4'b0010, 2'd3, 1'b0, 4'b0010, 2'd1, 1'b1);
        addVec(4'b1010, 2'd3, 1'b0, 4'b0010, 2'd1, 1'b0);
        addVec(4'b1000, 2'd3, 1'b0, 4'b1000, 2'd3, 1'b1);
        addVec(4'b0000, 2'd3, 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) addVec(4'b1111, 2'd1, 1'b1, 4'b0001, 2'd0, i == 0);
        addVec(4'b1111, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b1);
        addVec(4'b1111, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b0);

        // Held in reset with every channel requesting: nothing may be granted.
        rst_n = 1'b0;
        req = 4'b1111;
        quota = 2'd3;
        lock = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release between edges so the first table vector owns the first edge.
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].quota, vecs[i].lock);
            checkOutput($sformatf("vec%0d", i), vecs[i].grant, vecs[i].id,
                        vecs[i].grant != '0, vecs[i].gnew);
        end

        // Mid-burst asynchronous reset clears outputs without waiting for an edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_edge", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        modelReset();

        // First edge after reset must arbitrate from channel 0 again.
        applyStimulus(4'b1111, 2'd2, 1'b0);
        modelStep(4'b1111, 2'd2, 1'b0, eg, eid, ev, en);
        checkOutput("post_reset", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            rq = 2'($urandom_range(0, 3));
            rl = ($urandom_range(0, 5) == 0);
            applyStimulus(rr, rq, rl);
            modelStep(rr, rq, rl, eg, eid, ev, en);
            checkOutput($sformatf("rand%0d", i), eg, eid, ev, en);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
